// File: rtl/phase_sweep_pkg.sv
// Shared types and defaults for the MMCM phase sweep controller.
// Holds the FSM state enum, default parameters and step directions.
package phase_sweep_pkg;

  typedef enum logic [3:0] {
    IDLE,
    STEP,
    WAIT_DONE,
    SETTLE,
    DWELL,
    EVAL,
    PLAN,
    RETURN,
    RETURN_WAIT,
    DONE,
    ERR
  } sweep_state_t;

  localparam int unsigned DEF_NUM_STEPS      = 56;
  localparam int unsigned DEF_SETTLE_CYCLES  = 64;
  localparam int unsigned DEF_DWELL_CYCLES   = 1024;
  localparam int unsigned DEF_PSDONE_TIMEOUT = 4096;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/ps_step_issuer.sv
// Issues one MMCM phase step: one-cycle ps_en, then waits for ps_done.
// Ports: req/dir in, ps_en/ps_incdec out, ps_done in, ack/timeout out.
module ps_step_issuer
  import phase_sweep_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_PSDONE_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic dir,
  input  logic ps_done,
  output logic ps_en,
  output logic ps_incdec,
  output logic ack,
  output logic timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          en_q, en_d;
  logic          inc_q, inc_d;
  logic          wait_q, wait_d;
  logic [TW-1:0] cnt_q, cnt_d;

  // ps_done is only honoured once the strobe cycle is over; the
  // counter starts at the strobe so timeout lands TIMEOUT cycles later
  always_comb begin
    ack     = wait_q & ~en_q & ps_done;
    timeout = wait_q & ~ack
            & (cnt_q >= TW'(TIMEOUT - 1));
    en_d    = 1'b0;
    inc_d   = 1'b0;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    if (req && !wait_q) begin
      en_d   = 1'b1;
      inc_d  = dir;
      wait_d = 1'b1;
      cnt_d  = '0;
    end else if (wait_q) begin
      if (ack || timeout) begin
        wait_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      inc_q  <= 1'b0;
      wait_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      en_q   <= en_d;
      inc_q  <= inc_d;
      wait_q <= wait_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ps_en     = en_q;
  assign ps_incdec = inc_q;

endmodule

// File: rtl/phase_sweep_ctrl.sv
// Sweeps MMCM phase, finds the longest passing run, returns to its centre.
// Ports: start/sample_ok in, ps_* step port, busy/done/fail/timeout_err, results.
module phase_sweep_ctrl
  import phase_sweep_pkg::*;
#(
  parameter int unsigned NUM_STEPS      = DEF_NUM_STEPS,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned DWELL_CYCLES   = DEF_DWELL_CYCLES,
  parameter int unsigned PSDONE_TIMEOUT = DEF_PSDONE_TIMEOUT,
  parameter int unsigned POS_W          = $clog2(NUM_STEPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_ok,
  output logic             ps_en,
  output logic             ps_incdec,
  input  logic             ps_done,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             timeout_err,
  output logic [POS_W-1:0] cur_pos,
  output logic [POS_W-1:0] best_start,
  output logic [POS_W-1:0] best_len
);

  localparam int unsigned CMAX =
    (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int unsigned CW = $clog2(CMAX + 1);
  localparam logic [POS_W-1:0] LAST = POS_W'(NUM_STEPS - 1);

  sweep_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] rstart_q, rstart_d;
  logic [POS_W-1:0] rlen_q, rlen_d;
  logic [POS_W-1:0] bstart_q, bstart_d;
  logic [POS_W-1:0] blen_q, blen_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             terr_q, terr_d;
  logic [POS_W-1:0] rs, rl;
  logic             req, dir, ack, tmo;

  ps_step_issuer #(
    .TIMEOUT (PSDONE_TIMEOUT)
  ) u_issuer (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dir       (dir),
    .ps_done   (ps_done),
    .ps_en     (ps_en),
    .ps_incdec (ps_incdec),
    .ack       (ack),
    .timeout   (tmo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    pos_d    = pos_q;
    rstart_d = rstart_q;
    rlen_d   = rlen_q;
    bstart_d = bstart_q;
    blen_d   = blen_q;
    tgt_d    = tgt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fail_d   = fail_q;
    terr_d   = terr_q;
    rs       = (rlen_q == '0) ? pos_q : rstart_q;
    rl       = rlen_q + POS_W'(1);
    req      = 1'b0;
    dir      = DIR_INC;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d  = SETTLE;
          cnt_d    = '0;
          pos_d    = '0;
          rstart_d = '0;
          rlen_d   = '0;
          bstart_d = '0;
          blen_d   = '0;
          tgt_d    = '0;
          busy_d   = 1'b1;
          fail_d   = 1'b0;
          terr_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q >= CW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          pass_d  = 1'b1;
          state_d = DWELL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DWELL: begin
        pass_d = pass_q & sample_ok;
        if (cnt_q >= CW'(DWELL_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EVAL: begin
        if (pass_q) begin
          rstart_d = rs;
          rlen_d   = rl;
          // strict compare keeps the earliest run on ties
          if (rl > blen_q) begin
            bstart_d = rs;
            blen_d   = rl;
          end
        end else begin
          rlen_d = '0;
        end
        if (pos_q >= LAST) begin
          state_d = PLAN;
        end else begin
          req     = 1'b1;
          dir     = DIR_INC;
          state_d = STEP;
        end
      end
      STEP, WAIT_DONE: begin
        if (tmo) begin
          state_d = ERR;
          terr_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (ack && state_q == WAIT_DONE) begin
          pos_d   = pos_q + POS_W'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      PLAN: begin
        state_d = RETURN;
        if (blen_q == '0) begin
          fail_d = 1'b1;
          tgt_d  = '0;
        end else begin
          tgt_d = bstart_q + (blen_q >> 1);
        end
      end
      RETURN: begin
        if (pos_q == tgt_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          req     = 1'b1;
          dir     = DIR_DEC;
          state_d = RETURN_WAIT;
        end
      end
      RETURN_WAIT: begin
        if (tmo) begin
          state_d = ERR;
          terr_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (ack) begin
          pos_d   = pos_q - POS_W'(1);
          state_d = RETURN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      pos_q    <= '0;
      rstart_q <= '0;
      rlen_q   <= '0;
      bstart_q <= '0;
      blen_q   <= '0;
      tgt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      pos_q    <= pos_d;
      rstart_q <= rstart_d;
      rlen_q   <= rlen_d;
      bstart_q <= bstart_d;
      blen_q   <= blen_d;
      tgt_q    <= tgt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      terr_q   <= terr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign timeout_err = terr_q;
  assign cur_pos     = pos_q;
  assign best_start  = bstart_q;
  assign best_len    = blen_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Bench for phase_sweep_ctrl: directed and random pass maps vs a run model.
// MMCM stand-in answers each ps_en with ps_done three cycles later.
module tb_phase_sweep_ctrl;

  localparam int N  = 8;
  localparam int S  = 4;
  localparam int D  = 8;
  localparam int T  = 40;
  localparam int PW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sample_ok = 1'b0;
  logic ps_done = 1'b0;
  logic ps_en, ps_incdec, busy, done, fail, timeout_err;
  logic [PW-1:0] cur_pos, best_start, best_len;

  int n_pass = 0;
  int n_chk  = 0;

  phase_sweep_ctrl #(
    .NUM_STEPS      (N),
    .SETTLE_CYCLES  (S),
    .DWELL_CYCLES   (D),
    .PSDONE_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sample_ok   (sample_ok),
    .ps_en       (ps_en),
    .ps_incdec   (ps_incdec),
    .ps_done     (ps_done),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .timeout_err (timeout_err),
    .cur_pos     (cur_pos),
    .best_start  (best_start),
    .best_len    (best_len)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic [2:0]    sh = '0;
  logic          stray = 1'b0;
  logic          en_prev = 1'b0;
  logic [7:0]    mask = '0;
  logic [PW-1:0] last_pos = '0;
  int step_no = 0, suppress_step = 0;
  int inc_steps = 0, dec_steps = 0;
  int en_wide = 0, done_cnt = 0;
  int glitch_pos = -1, pos_cyc = 0;
  int unsigned last_en_cyc = 0;

  // MMCM + checker stand-in, everything changes on the falling edge
  always @(negedge clk) begin
    ps_done = sh[2] | stray;
    sh = {sh[1:0], 1'b0};
    if (ps_en === 1'b1) begin
      step_no++;
      last_en_cyc = cyc;
      if (ps_incdec) inc_steps++;
      else dec_steps++;
      if (step_no != suppress_step) sh[0] = 1'b1;
      if (en_prev) en_wide++;
    end
    en_prev = ps_en;
    if (done === 1'b1) done_cnt++;
    if (cur_pos != last_pos) pos_cyc = 0;
    else pos_cyc++;
    last_pos = cur_pos;
    sample_ok = mask[cur_pos[2:0]]
      && !(int'(cur_pos) == glitch_pos && pos_cyc == 8);
  end

  // longest all-pass interval by brute force; earliest wins ties
  function automatic void model(input logic [7:0] p,
                                output int bs, output int bl,
                                output int tg);
    bs = 0;
    bl = 0;
    for (int s = 0; s < N; s++)
      for (int e = s; e < N; e++) begin
        bit all = 1'b1;
        for (int k = s; k <= e; k++) if (!p[k]) all = 1'b0;
        if (all && (e - s + 1) > bl) begin
          bs = s;
          bl = e - s + 1;
        end
      end
    tg = (bl == 0) ? 0 : bs + bl / 2;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input logic [7:0] m, input int g,
                           input string nm);
    logic [7:0] eff;
    int bs, bl, tg, w;
    eff = m;
    if (g >= 0) eff[g] = 1'b0;
    model(eff, bs, bl, tg);
    mask = m;
    glitch_pos = g;
    suppress_step = 0;
    step_no = 0;
    inc_steps = 0;
    dec_steps = 0;
    en_wide = 0;
    pulse_start();
    n_chk++;
    if (busy !== 1'b1 || timeout_err !== 1'b0)
      $display("FAIL %s busy_after_start got %b/%b want 1/0",
               nm, busy, timeout_err);
    else n_pass++;
    done_cnt = 0;
    w = 0;
    while (done !== 1'b1 && timeout_err !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done got %b busy %b want 1/0", nm, done, busy);
    else n_pass++;
    n_chk++;
    if (best_start !== PW'(bs) || best_len !== PW'(bl))
      $display("FAIL %s best got %0d/%0d want %0d/%0d",
               nm, best_start, best_len, bs, bl);
    else n_pass++;
    n_chk++;
    if (cur_pos !== PW'(tg))
      $display("FAIL %s cur_pos got %0d want %0d", nm, cur_pos, tg);
    else n_pass++;
    n_chk++;
    if (fail !== (bl == 0))
      $display("FAIL %s fail got %b want %b", nm, fail, bl == 0);
    else n_pass++;
    n_chk++;
    if (inc_steps != N - 1 || dec_steps != N - 1 - tg || en_wide != 0)
      $display("FAIL %s steps got inc %0d dec %0d wide %0d want %0d %0d 0",
               nm, inc_steps, dec_steps, en_wide, N - 1, N - 1 - tg);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if (done !== 1'b0 || done_cnt != 1)
      $display("FAIL %s done_pulse got %b cnt %0d want 0 cnt 1",
               nm, done, done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ps_en, ps_incdec, busy, done, fail, timeout_err,
         cur_pos, best_start, best_len} !== '0)
      $display("FAIL reset_state got %b want 0", {ps_en, busy, done,
               fail, timeout_err, cur_pos, best_start, best_len});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_sweep(8'hFF, -1, "all_pass");
    run_sweep(8'b0011_1100, -1, "mid_run");
    run_sweep(8'b0110_0110, -1, "tie");
    run_sweep(8'h00, -1, "never");
    run_sweep(8'hFF, 3, "glitch3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] m;
      int g;
      m = 8'($urandom);
      g = $urandom_range(1, 10);
      if (g > 7) g = -1;
      run_sweep(m, g, "random");
    end
  endtask

  task automatic test_timeout();
    int w;
    mask = 8'hFF;
    glitch_pos = -1;
    step_no = 0;
    suppress_step = 2;
    pulse_start();
    w = 0;
    while (timeout_err !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_flag got %b busy %b want 1/0",
               timeout_err, busy);
    else n_pass++;
    n_chk++;
    if (cyc - last_en_cyc != T)
      $display("FAIL timeout_delay got %0d want %0d",
               cyc - last_en_cyc, T);
    else n_pass++;
    n_chk++;
    if (cur_pos !== PW'(1) || done !== 1'b0)
      $display("FAIL timeout_pos got %0d done %b want 1/0", cur_pos, done);
    else n_pass++;
    suppress_step = 0;
    run_sweep(8'hFF, -1, "after_err");
  endtask

  task automatic test_reset_mid_dwell();
    int w;
    mask = 8'hFF;
    glitch_pos = -1;
    suppress_step = 0;
    pulse_start();
    w = 0;
    while (cur_pos !== PW'(2) && w < 500) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (cur_pos !== PW'(2))
      $display("FAIL reach_pos2 got %0d want 2", cur_pos);
    else n_pass++;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ps_en, ps_incdec, busy, done, fail, timeout_err,
         cur_pos, best_start, best_len} !== '0)
      $display("FAIL reset_mid_dwell got %b want 0", {busy, fail,
               cur_pos, best_start, best_len});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (cur_pos !== '0 || busy !== 1'b0 || ps_en !== 1'b0)
      $display("FAIL stray_psdone got pos %0d busy %b want 0/0",
               cur_pos, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_reset_mid_dwell();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
